// File: rtl/crtc_pkg.sv
// Shared register map, cursor mode encoding and small helpers for the CRTC.
package crtc_pkg;

    // Register indices as seen through the host address register
    localparam logic [4:0] R_HTOTAL    = 5'd0;
    localparam logic [4:0] R_HDISP     = 5'd1;
    localparam logic [4:0] R_HSYNCPOS  = 5'd2;
    localparam logic [4:0] R_SYNCWIDTH = 5'd3;
    localparam logic [4:0] R_VTOTAL    = 5'd4;
    localparam logic [4:0] R_VTOTALADJ = 5'd5;
    localparam logic [4:0] R_VDISP     = 5'd6;
    localparam logic [4:0] R_VSYNCPOS  = 5'd7;
    localparam logic [4:0] R_INTERLACE = 5'd8;
    localparam logic [4:0] R_MAXSCAN   = 5'd9;
    localparam logic [4:0] R_CSTART    = 5'd10;
    localparam logic [4:0] R_CEND      = 5'd11;
    localparam logic [4:0] R_START_HI  = 5'd12;
    localparam logic [4:0] R_START_LO  = 5'd13;
    localparam logic [4:0] R_CURSOR_HI = 5'd14;
    localparam logic [4:0] R_CURSOR_LO = 5'd15;
    localparam logic [4:0] R_LPEN_HI   = 5'd16;
    localparam logic [4:0] R_LPEN_LO   = 5'd17;

    // Cursor mode held in R10[6:5]
    typedef enum logic [1:0] {
        CUR_STEADY  = 2'b00,
        CUR_OFF     = 2'b01,
        CUR_BLINK16 = 2'b10,
        CUR_BLINK32 = 2'b11
    } cur_mode_e;

    // Cursor visibility for the mode; b16/b32 are field-counter bits 3 and 4
    function automatic logic cursor_blink(input cur_mode_e mode, input logic b16, input logic b32);
        case (mode)
            CUR_STEADY:  return 1'b1;
            CUR_OFF:     return 1'b0;
            CUR_BLINK16: return b16;
            default:     return b32;
        endcase
    endfunction

    // Sync pulse width nibble: zero encodes the maximum of 16
    function automatic logic [4:0] sync_width(input logic [3:0] w);
        return (w == 4'd0) ? 5'd16 : {1'b0, w};
    endfunction

endpackage

// File: rtl/crtc_lpen_sync.sv
// Two-flop synchroniser for the asynchronous light-pen strobe plus rising-edge detect.
module crtc_lpen_sync (
    input  logic clk,
    input  logic reset,
    input  logic lpen,
    output logic rise
);
    // [0] metastability flop, [1] synchronised level, [2] previous level
    logic [2:0] sync_q;

    // Shift the strobe through the synchroniser chain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[1:0], lpen};
    end

    assign rise = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/crtc_param.sv
// 6845-style CRT controller: host register file, horizontal/vertical timing,
// refresh address generation, cursor and light-pen capture.
module crtc_param #(
    parameter int          MA_W       = 14,
    parameter int          RA_W       = 5,
    parameter logic [7:0]  H_TOTAL    = 8'd0,
    parameter logic [7:0]  H_DISP     = 8'd0,
    parameter logic [7:0]  H_SYNCPOS  = 8'd0,
    parameter logic [7:0]  SYNCWIDTH  = 8'd0,
    parameter logic [7:0]  V_TOTAL    = 8'd0,
    parameter logic [7:0]  V_TOTALADJ = 8'd0,
    parameter logic [7:0]  V_DISP     = 8'd0,
    parameter logic [7:0]  V_SYNCPOS  = 8'd0,
    parameter logic [7:0]  V_MAXSCAN  = 8'd0,
    parameter logic [7:0]  C_START    = 8'd0,
    parameter logic [7:0]  C_END      = 8'd0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            divclk,
    input  logic            cs,
    input  logic            a0,
    input  logic            write,
    input  logic            read,
    input  logic [7:0]      bus,
    output logic [7:0]      bus_out,
    input  logic            lock,
    input  logic            lpen,
    output logic            hsync,
    output logic            vsync,
    output logic            display_enable,
    output logic            cursor,
    output logic [MA_W-1:0] mem_addr,
    output logic [RA_W-1:0] row_addr,
    output logic            line_reset,
    output logic            frame_start
);
    import crtc_pkg::*;

    // Host-visible registers
    logic [4:0]      addr;
    logic [7:0]      r_htotal, r_hdisp, r_hsyncpos, r_syncwidth;
    logic [6:0]      r_vtotal, r_vdisp, r_vsyncpos, r_cstart;
    logic [RA_W-1:0] r_vadj, r_maxscan;
    logic [4:0]      r_cend;
    logic [5:0]      r_start_hi, r_cur_hi;
    logic [7:0]      r_start_lo, r_cur_lo;
    logic [13:0]     lpen_addr;

    // Timing state
    logic [7:0]      h_count;
    logic [6:0]      v_row;
    logic [4:0]      hs_rem, vs_rem;
    logic            hdisp, vdisp;
    logic [MA_W-1:0] row_base, start_lat;
    logic [4:0]      blink_cnt;

    logic [7:0]      h_next;
    logic [6:0]      v_next;
    logic [RA_W-1:0] row_end;
    logic            line_adv, row_change, frame_wrap, lpen_rise;
    logic [7:0]      rd_data;

    assign line_reset = (h_count == r_htotal);
    assign h_next     = h_count + 8'd1;
    assign v_next     = v_row + 7'd1;
    // The last row of a frame stretches by the vertical adjust
    assign row_end    = (v_row == r_vtotal) ? r_maxscan + r_vadj : r_maxscan;
    assign line_adv   = divclk & line_reset;
    assign row_change = line_adv & (row_addr == row_end);
    assign frame_wrap = row_change & (v_row == r_vtotal);

    // Host address/data register writes; lock protects the timing set R0-R9
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr        <= '0;
            r_htotal    <= H_TOTAL;
            r_hdisp     <= H_DISP;
            r_hsyncpos  <= H_SYNCPOS;
            r_syncwidth <= SYNCWIDTH;
            r_vtotal    <= V_TOTAL[6:0];
            r_vadj      <= RA_W'(V_TOTALADJ);
            r_vdisp     <= V_DISP[6:0];
            r_vsyncpos  <= V_SYNCPOS[6:0];
            r_maxscan   <= RA_W'(V_MAXSCAN);
            r_cstart    <= C_START[6:0];
            r_cend      <= C_END[4:0];
            r_start_hi  <= '0;
            r_start_lo  <= '0;
            r_cur_hi    <= '0;
            r_cur_lo    <= '0;
        end else if (cs && write) begin
            if (!a0) begin
                addr <= bus[4:0];
            end else begin
                case (addr)
                    R_HTOTAL:    if (!lock) r_htotal    <= bus;
                    R_HDISP:     if (!lock) r_hdisp     <= bus;
                    R_HSYNCPOS:  if (!lock) r_hsyncpos  <= bus;
                    R_SYNCWIDTH: if (!lock) r_syncwidth <= bus;
                    R_VTOTAL:    if (!lock) r_vtotal    <= bus[6:0];
                    R_VTOTALADJ: if (!lock) r_vadj      <= RA_W'(bus);
                    R_VDISP:     if (!lock) r_vdisp     <= bus[6:0];
                    R_VSYNCPOS:  if (!lock) r_vsyncpos  <= bus[6:0];
                    R_MAXSCAN:   if (!lock) r_maxscan   <= RA_W'(bus);
                    R_CSTART:    r_cstart   <= bus[6:0];
                    R_CEND:      r_cend     <= bus[4:0];
                    R_START_HI:  r_start_hi <= bus[5:0];
                    R_START_LO:  r_start_lo <= bus;
                    R_CURSOR_HI: r_cur_hi   <= bus[5:0];
                    R_CURSOR_LO: r_cur_lo   <= bus;
                    default: ;
                endcase
            end
        end
    end

    // Read mux: narrow registers zero-extend, write-only/unused slots read 0
    always_comb begin
        rd_data = 8'h00;
        case (addr)
            R_HTOTAL:    rd_data = r_htotal;
            R_HDISP:     rd_data = r_hdisp;
            R_HSYNCPOS:  rd_data = r_hsyncpos;
            R_SYNCWIDTH: rd_data = r_syncwidth;
            R_VTOTAL:    rd_data = {1'b0, r_vtotal};
            R_VTOTALADJ: rd_data = 8'(r_vadj);
            R_VDISP:     rd_data = {1'b0, r_vdisp};
            R_VSYNCPOS:  rd_data = {1'b0, r_vsyncpos};
            R_MAXSCAN:   rd_data = 8'(r_maxscan);
            R_CSTART:    rd_data = {1'b0, r_cstart};
            R_CEND:      rd_data = {3'b000, r_cend};
            R_START_HI:  rd_data = {2'b00, r_start_hi};
            R_START_LO:  rd_data = r_start_lo;
            R_CURSOR_HI: rd_data = {2'b00, r_cur_hi};
            R_CURSOR_LO: rd_data = r_cur_lo;
            R_LPEN_HI:   rd_data = {2'b00, lpen_addr[13:8]};
            R_LPEN_LO:   rd_data = lpen_addr[7:0];
            default:     rd_data = 8'h00;
        endcase
        bus_out = (cs && read) ? rd_data : 8'h00;
    end

    // Horizontal counter, display window and hsync pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_count <= '0;
            hdisp   <= 1'b1;
            hsync   <= 1'b0;
            hs_rem  <= '0;
        end else if (divclk) begin
            h_count <= line_reset ? 8'd0 : h_next;
            if (line_reset)            hdisp <= 1'b1;
            else if (h_next == r_hdisp) hdisp <= 1'b0;
            if (h_next == r_hsyncpos) begin
                hsync  <= 1'b1;
                hs_rem <= sync_width(r_syncwidth[3:0]);
            end else if (hsync) begin
                if (hs_rem == 5'd1) hsync  <= 1'b0;
                else                hs_rem <= hs_rem - 5'd1;
            end
        end
    end

    // Scan-line/row counters, vertical window, vsync, refresh base and field count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_addr    <= '0;
            v_row       <= '0;
            vdisp       <= 1'b1;
            vsync       <= 1'b0;
            vs_rem      <= '0;
            row_base    <= '0;
            start_lat   <= '0;
            blink_cnt   <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_wrap;
            if (line_adv) begin
                if (frame_wrap) begin
                    row_addr <= '0;
                    v_row    <= '0;
                end else if (row_change) begin
                    row_addr <= '0;
                    v_row    <= v_next;
                end else begin
                    row_addr <= row_addr + RA_W'(1);
                end

                if (frame_wrap)                          vdisp <= 1'b1;
                else if (row_change && v_next == r_vdisp) vdisp <= 1'b0;

                if (row_change && v_next == r_vsyncpos) begin
                    vsync  <= 1'b1;
                    vs_rem <= sync_width(r_syncwidth[7:4]);
                end else if (vsync) begin
                    if (vs_rem == 5'd1) vsync  <= 1'b0;
                    else                vs_rem <= vs_rem - 5'd1;
                end

                // Start address is only sampled here so a new origin never tears
                if (frame_wrap) begin
                    row_base  <= '0;
                    start_lat <= MA_W'({r_start_hi, r_start_lo});
                    blink_cnt <= blink_cnt + 5'd1;
                end else if (row_addr == r_maxscan) begin
                    row_base  <= row_base + MA_W'(r_hdisp);
                end
            end
        end
    end

    assign mem_addr       = start_lat + row_base + MA_W'(h_count);
    assign display_enable = hdisp & vdisp;
    assign cursor = (mem_addr == MA_W'({r_cur_hi, r_cur_lo}))
                 && ({3'b000, r_cstart[4:0]} <= 8'(row_addr))
                 && (8'(row_addr) <= {3'b000, r_cend})
                 && display_enable
                 && cursor_blink(cur_mode_e'(r_cstart[6:5]), blink_cnt[3], blink_cnt[4]);

    crtc_lpen_sync u_lpen (
        .clk   (clk),
        .reset (reset),
        .lpen  (lpen),
        .rise  (lpen_rise)
    );

    // Capture the refresh address one clock after a synchronised pen edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          lpen_addr <= '0;
        else if (lpen_rise) lpen_addr <= 14'(mem_addr);
    end
endmodule
